// File: rtl/run_ctrl_pkg.sv
// Shared types and helpers for the run controller: FSM state encoding,
// the ebreak halt encoding and the data-signature fold.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CORE_RST = 3'd1,
    SETTLE   = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } run_state_t;

  localparam logic [31:0] HALT_EBREAK = 32'h00100073;

  // Widest signature the fold helper supports; callers pass their real width.
  localparam int SIG_MAX_W = 64;

  // Rotate-left-by-one within the low 'width' bits, then xor in the new data word.
  function automatic logic [SIG_MAX_W-1:0] sig_fold(input logic [SIG_MAX_W-1:0] sig,
                                                    input logic [SIG_MAX_W-1:0] data,
                                                    input int width);
    logic [SIG_MAX_W-1:0] rot;
    rot = '0;
    for (int i = 0; i < SIG_MAX_W; i++) begin
      if (i == 0) rot[i] = sig[width-1];
      else if (i < width) rot[i] = sig[i-1];
    end
    return rot ^ data;
  endfunction

endpackage

// File: rtl/run_ctrl_trace_buf.sv
// Circular trace of the most recent instructions; the oldest entry is dropped
// when a write arrives while full. Pops return data one cycle later.
module run_ctrl_trace_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (full) rd_ptr <= rd_ptr + 1'b1;
    end else if (rd_en && !empty) begin
      rd_data <= mem[rd_ptr[AW-1:0]];
      rd_ptr  <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences core reset/start, counts fetch beats, detects halt,
// enforces a cycle watchdog and folds a data signature. RUN_CTRL_TRACE_EN adds a trace buffer.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RST_CYC    = 2,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_CYC    = 30,
  parameter int CNT_WIDTH  = 16,
`ifdef RUN_CTRL_TRACE_EN
  parameter int TRACE_DEPTH = 8,
`endif
  parameter logic [INST_WIDTH-1:0] HALT_INST = INST_WIDTH'(HALT_EBREAK)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [DATA_WIDTH-1:0] exp_sig,
  input  logic [INST_WIDTH-1:0] fetch_inst,
  input  logic                  inst_valid,
  input  logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  data_valid,
`ifdef RUN_CTRL_TRACE_EN
  input  logic                  trace_rd,
  output logic [INST_WIDTH-1:0] trace_data,
  output logic                  trace_empty,
`endif
  output logic                  core_rst_n,
  output logic                  start,
  output logic                  running,
  output logic                  done,
  output logic                  timeout,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output logic [CNT_WIDTH-1:0]  inst_cnt,
  output logic [CNT_WIDTH-1:0]  data_cnt,
  output logic [DATA_WIDTH-1:0] signature,
  output logic [2:0]            dbg_state
);

  localparam int PH_W = 16;

  run_state_t            state;
  logic [PH_W-1:0]       phase_cnt;
  logic                  go_accept;
  logic                  halt_hit;
  logic                  limit_hit;
  logic [DATA_WIDTH-1:0] sig_next;
  logic [DATA_WIDTH-1:0] sig_final;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign dbg_state = state;
  assign go_accept = go && (state == IDLE || state == DONE);
  assign halt_hit  = (state == RUN) && inst_valid && (fetch_inst == HALT_INST);
  assign limit_hit = (state == RUN) && (cycle_cnt == CNT_WIDTH'(MAX_CYC - 1));
  assign sig_next  = DATA_WIDTH'(sig_fold(SIG_MAX_W'(signature), SIG_MAX_W'(fetch_data), DATA_WIDTH));
  // The verdict must include a data beat that lands on the final RUN cycle.
  assign sig_final = data_valid ? sig_next : signature;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      core_rst_n <= 1'b0;
      start      <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      pass       <= 1'b0;
      cycle_cnt  <= '0;
      inst_cnt   <= '0;
      data_cnt   <= '0;
      signature  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          core_rst_n <= 1'b1;
          if (go_accept) begin
            state      <= CORE_RST;
            phase_cnt  <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            pass       <= 1'b0;
            cycle_cnt  <= '0;
            inst_cnt   <= '0;
            data_cnt   <= '0;
            signature  <= '0;
          end
        end
        CORE_RST: begin
          if (phase_cnt == PH_W'(RST_CYC - 1)) begin
            phase_cnt  <= '0;
            core_rst_n <= 1'b1;
            if (SETTLE_CYC == 0) begin
              state   <= RUN;
              start   <= 1'b1;
              running <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (phase_cnt == PH_W'(SETTLE_CYC - 1)) begin
            phase_cnt <= '0;
            state     <= RUN;
            start     <= 1'b1;
            running   <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        RUN: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (inst_valid) inst_cnt <= sat_inc(inst_cnt);
          if (data_valid) begin
            data_cnt  <= sat_inc(data_cnt);
            signature <= sig_next;
          end
          // Halt takes priority over the watchdog on the same cycle.
          if (halt_hit || limit_hit) begin
            state   <= DONE;
            start   <= 1'b0;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= !halt_hit;
            pass    <= halt_hit && (sig_final == exp_sig);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RUN_CTRL_TRACE_EN
  run_ctrl_trace_buf #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (INST_WIDTH)
  ) u_trace (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (go_accept),
    .wr_en   ((state == RUN) && inst_valid),
    .wr_data (fetch_inst),
    .rd_en   ((state == DONE) && trace_rd),
    .rd_data (trace_data),
    .empty   (trace_empty)
  );
`endif

endmodule
